// File: rtl/alu_core.sv
// ----------------------------------------------------------------------------
// alu_core: sequential unsigned ALU.
// Logic, shift and add/sub ops complete on the capture edge. MUL (shift-add)
// and DIV/MOD (restoring division) take one iteration per clock for WIDTH
// clocks. Divide-by-zero and the unused op codes finish on the capture edge
// and raise error.
// ----------------------------------------------------------------------------
module alu_core #(
   parameter int WIDTH    = 8,
   parameter int OP_WIDTH = 4
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [WIDTH-1:0]    input_a,
   input  logic [WIDTH-1:0]    input_b,
   input  logic [OP_WIDTH-1:0] operator,
   output logic                calculated,
   output logic [WIDTH-1:0]    result,
   output logic                busy,
   output logic                error
);

   // Operator encodings
   localparam logic [OP_WIDTH-1:0] OP_NOP = OP_WIDTH'(0);
   localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(1);
   localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(2);
   localparam logic [OP_WIDTH-1:0] OP_AND = OP_WIDTH'(3);
   localparam logic [OP_WIDTH-1:0] OP_OR  = OP_WIDTH'(4);
   localparam logic [OP_WIDTH-1:0] OP_XOR = OP_WIDTH'(5);
   localparam logic [OP_WIDTH-1:0] OP_NOT = OP_WIDTH'(6);
   localparam logic [OP_WIDTH-1:0] OP_SHL = OP_WIDTH'(7);
   localparam logic [OP_WIDTH-1:0] OP_SHR = OP_WIDTH'(8);
   localparam logic [OP_WIDTH-1:0] OP_MUL = OP_WIDTH'(9);
   localparam logic [OP_WIDTH-1:0] OP_DIV = OP_WIDTH'(10);
   localparam logic [OP_WIDTH-1:0] OP_MOD = OP_WIDTH'(11);

   // Iteration counter is wide enough to hold WIDTH-1
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   typedef enum logic {
      S_IDLE,
      S_ITER
   } state_t;

   typedef enum logic [1:0] {
      K_MUL,
      K_DIV,
      K_MOD
   } kind_t;

   state_t           r_state;
   kind_t            r_kind;
   logic [CNT_W-1:0] r_cnt;
   // r_acc:  product accumulator (MUL) or partial remainder (DIV/MOD)
   // r_opa:  multiplicand shifted left (MUL) or dividend/quotient shift reg
   // r_opb:  multiplier shifted right (MUL) or constant divisor (DIV/MOD)
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_opa;
   logic [WIDTH-1:0] r_opb;

   // Capture-edge decode
   logic [WIDTH-1:0] w_single_res;
   logic             w_single_err;
   logic             w_start_iter;
   kind_t            w_start_kind;

   // Iteration datapath
   logic [WIDTH-1:0] w_mul_acc;
   logic [WIDTH:0]   w_rem_shift;
   logic [WIDTH:0]   w_diff;
   logic             w_div_fit;
   logic [WIDTH-1:0] w_div_rem;
   logic [WIDTH-1:0] w_div_quot;
   logic [WIDTH-1:0] w_final_res;

   // Decode the presented operator into a one-cycle result or an iterative start
   always_comb begin
      // NOTE: every output of this block gets a default first so that no path leaves it unassigned and infers a latch.
      w_single_res = '0;
      w_single_err = 1'b0;
      w_start_iter = 1'b0;
      w_start_kind = K_MUL;
      case (operator)
         OP_ADD: w_single_res = input_a + input_b;
         OP_SUB: w_single_res = input_a - input_b;
         OP_AND: w_single_res = input_a & input_b;
         OP_OR:  w_single_res = input_a | input_b;
         OP_XOR: w_single_res = input_a ^ input_b;
         OP_NOT: w_single_res = ~input_a;
         OP_SHL: w_single_res = input_a << input_b[2:0];
         OP_SHR: w_single_res = input_a >> input_b[2:0];
         OP_MUL: begin
            w_start_iter = 1'b1;
            w_start_kind = K_MUL;
         end
         OP_DIV: begin
            if (input_b == '0) begin
               w_single_res = '1;
               w_single_err = 1'b1;
            end else begin
               w_start_iter = 1'b1;
               w_start_kind = K_DIV;
            end
         end
         OP_MOD: begin
            if (input_b == '0) begin
               w_single_res = input_a;
               w_single_err = 1'b1;
            end else begin
               w_start_iter = 1'b1;
               w_start_kind = K_MOD;
            end
         end
         default: begin
            // Illegal codes (NOP never reaches the capture path)
            w_single_res = '0;
            w_single_err = 1'b1;
         end
      endcase
   end

   // One shift-add step and one restoring-division step, plus the final pick
   always_comb begin
      w_mul_acc   = r_opb[0] ? (r_acc + r_opa) : r_acc;
      w_rem_shift = {r_acc, r_opa[WIDTH-1]};
      w_diff      = w_rem_shift - {1'b0, r_opb};
      // No borrow out of the top bit means the divisor fits this step
      w_div_fit   = ~w_diff[WIDTH];
      w_div_rem   = w_div_fit ? w_diff[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];
      w_div_quot  = {r_opa[WIDTH-2:0], w_div_fit};
      case (r_kind)
         K_DIV:   w_final_res = w_div_quot;
         K_MOD:   w_final_res = w_div_rem;
         default: w_final_res = w_mul_acc;
      endcase
   end

   // Control FSM with registered status outputs and iterative datapath state
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         // NOTE: state and outputs use non-blocking assignments so every register samples pre-edge values regardless of statement order.
         r_state    <= S_IDLE;
         r_kind     <= K_MUL;
         r_cnt      <= '0;
         r_acc      <= '0;
         r_opa      <= '0;
         r_opb      <= '0;
         calculated <= 1'b0;
         result     <= '0;
         busy       <= 1'b0;
         error      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               calculated <= 1'b0;
               if (operator != OP_NOP) begin
                  if (w_start_iter) begin
                     r_state <= S_ITER;
                     r_kind  <= w_start_kind;
                     r_cnt   <= '0;
                     r_acc   <= '0;
                     r_opa   <= input_a;
                     r_opb   <= input_b;
                     busy    <= 1'b1;
                  end else begin
                     result     <= w_single_res;
                     error      <= w_single_err;
                     calculated <= 1'b1;
                  end
               end
            end

            S_ITER: begin
               // operator is deliberately ignored while iterating
               if (r_kind == K_MUL) begin
                  r_acc <= w_mul_acc;
                  r_opa <= r_opa << 1;
                  r_opb <= r_opb >> 1;
               end else begin
                  r_acc <= w_div_rem;
                  r_opa <= w_div_quot;
               end
               if (r_cnt == LAST_ITER) begin
                  r_state    <= S_IDLE;
                  result     <= w_final_res;
                  error      <= 1'b0;
                  calculated <= 1'b1;
                  busy       <= 1'b0;
               end else begin
                  r_cnt      <= r_cnt + 1'b1;
                  calculated <= 1'b0;
               end
            end

            default: begin
               r_state    <= S_IDLE;
               calculated <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
Sequential 8-bit ALU, the design-under-test block that consumes input_a/input_b/operator from the ALU driver clocking block and produces calculated/result for the ALU monitor.
- Logic and add/sub ops complete in one cycle.
- MUL/DIV/MOD are iterative over WIDTH cycles, sequenced by a small FSM.
- Adds busy and error status outputs alongside the bus signals.

Parameters:
WIDTH, 8, operand/result width; also the MUL/DIV/MOD iteration count
OP_WIDTH, 4, operator code width

Ports:
clock  input  1  single clock; all state updates on posedge
reset_n  input  1  synchronous active-low reset, sampled on posedge clock
input_a  input  WIDTH  operand A
input_b  input  WIDTH  operand B
operator  input  OP_WIDTH  op code; 0 = NOP/idle
calculated  output  1  one-cycle pulse: result/error valid
result  output  WIDTH  op result; holds last value until next completion
busy  output  1  high while a multi-cycle op is in flight
error  output  1  valid with calculated; divide-by-zero or illegal op

Behaviour:
Interface:
- One clock (clock); reset is synchronous, active-low (reset_n).

Reset:
- reset_n low at a posedge forces state IDLE and calculated=0, result=0, busy=0, error=0.
- Any in-flight op is discarded; no calculated pulse is issued for it.

FSM states IDLE, ITER:
- IDLE: at a posedge with operator!=0, capture input_a, input_b and operator (edge E0).
- Single-cycle op at E0: result<=f(a,b), calculated<=1, error set per op; stay in IDLE.
- MUL/DIV/MOD at E0: busy<=1, go to ITER, iteration counter<=0.
- ITER: one iteration per edge, E1..E(WIDTH). At E(WIDTH): result<=final value, calculated<=1, busy<=0, return to IDLE. Default WIDTH=8 completes at E8.
- operator is ignored while busy=1. The driver must wait for calculated before issuing the next multi-cycle op.
- calculated deasserts on the next edge unless a new single-cycle op completes on that edge.
- Back-to-back single-cycle ops keep calculated high continuously, with one result per cycle.
- New ops are accepted starting the edge after a multi-cycle completion (E(WIDTH)+1).

Op codes (all arithmetic modulo 2^WIDTH, unsigned):
- 1 ADD a+b
- 2 SUB a-b
- 3 AND
- 4 OR
- 5 XOR
- 6 NOT a (b ignored)
- 7 SHL: a << b[2:0]
- 8 SHR: logical, a >> b[2:0]
- 9 MUL: low WIDTH bits of a*b, shift-add, one partial product per iteration
- 10 DIV: a/b, restoring division, one quotient bit per iteration
- 11 MOD: a%b, same datapath as DIV
- 12-15 illegal: single-cycle; result=0, error=1

Divide by zero:
- Detected at E0; single-cycle completion, no ITER.
- DIV gives result=all ones. MOD gives result=a.
- error=1 for both.

error:
- error=0 for all other legal ops.
- error updates only when calculated is asserted.

Other rules:
- result is unchanged while busy and when idle.
- reset_n low during ITER takes priority over completion, even on the completion edge.

Test Plan:
- ADD a=200 b=100 at E0 -> after E0: calculated=1, result=44, error=0; after E1 (operator=0): calculated=0, result still 44.
- SUB 5-10, then AND 0xF0&0x3C on consecutive edges -> calculated high two cycles, result 251 then 0x30.
- MUL 15*17 at E0 -> busy=1 after E0..E7, calculated=1 and result=255 after E8 only, busy=0; MUL 20*20 -> result=144.
- DIV 100/7 -> result=14 after E8; MOD 100%7 -> result=2; DIV 9/0 -> after E0 result=0xFF, error=1, busy never high.
- MUL 3*4 at E0; at E3 drive ADD 1+1 -> ADD ignored; single calculated with result=12 after E8; ADD issued at E9 -> result=2 after E9.
- MUL started, reset_n low at E4 -> after E4 all outputs 0, state IDLE; no calculated through E10; op code 13 after reset -> result=0, error=1, calculated one cycle.
